// File: rtl/mb_add_seq_pkg.sv
// Shared types and defaults for the multi-byte serial add/subtract block.
package mb_add_seq_pkg;

  // Default width of the len field; operands are up to 2**LEN_W bytes.
  localparam int LEN_W_DEF = 3;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/mb_add_seq_cla.sv
// cla8: purely combinational 8-bit carry-lookahead adder with group P/G.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       c8,
  output logic       p,
  output logic       g
);

  logic [7:0] gen_b;
  logic [7:0] prop_b;
  logic [8:0] carry;
  logic [8:0] carry_nocin;

  // Every carry is formed directly from the per-bit generate/propagate terms
  // and cin, rather than rippling through the previous carry.
  function automatic logic [8:0] lookahead(input logic [7:0] gi,
                                           input logic [7:0] pi,
                                           input logic       ci);
    logic [8:0] c;
    logic       gg;
    logic       pp;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j <= i; j++) begin
        gg = gi[j] | (pi[j] & gg);
        pp = pp & pi[j];
      end
      c[i+1] = gg | (pp & ci);
    end
    return c;
  endfunction

  // Bitwise generate/propagate, lookahead carries and the sum bits.
  always_comb begin
    gen_b       = a & b;
    prop_b      = a ^ b;
    carry       = lookahead(gen_b, prop_b, cin);
    carry_nocin = lookahead(gen_b, prop_b, 1'b0);
    s           = prop_b ^ carry[7:0];
    c8          = carry[8];
    p           = &prop_b;
    g           = carry_nocin[8];
  end

endmodule

// File: rtl/mb_add_seq.sv
// mb_add_seq: serial multi-byte A+B / A-B, one byte pair per cycle, LS byte
// first. Handshakes: a transfer happens on a rising edge where valid and
// ready are both high; valid never waits on ready, and a producer holding
// valid keeps its data stable until the transfer.
module mb_add_seq
  import mb_add_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a_byte,
  input  logic [7:0]       b_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       sum_byte,
  output logic             out_last,
  output logic             carry_out,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  state_e           state_q;
  logic             sub_q;
  logic [LEN_W-1:0] cnt_q;
  logic             carry_q;
  logic [7:0]       sum_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             carry_out_q;
  logic             ovf_q;
  logic             done_q;

  logic [7:0]       b_eff;
  logic [7:0]       add_s;
  logic             add_c8;
  logic             unused_p;
  logic             unused_g;
  logic             in_acc;
  logic             out_acc;
  logic             ovf_d;

  // Operand conditioning, handshakes and the signed-overflow term.
  always_comb begin
    b_eff    = b_byte ^ {8{sub_q}};
    in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    in_acc   = in_valid && in_ready;
    out_acc  = out_valid_q && out_ready;
    ovf_d    = (a_byte[7] == b_eff[7]) && (add_s[7] != a_byte[7]);
  end

  cla8 u_cla (
    .a   (a_byte),
    .b   (b_eff),
    .cin (carry_q),
    .s   (add_s),
    .c8  (add_c8),
    .p   (unused_p),
    .g   (unused_g)
  );

  // Controller: sequences the bytes and registers every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sub_q   <= sub;
            cnt_q   <= len;
            carry_q <= sub;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (in_acc) begin
            sum_q       <= add_s;
            out_valid_q <= 1'b1;
            carry_q     <= add_c8;
            if (cnt_q == '0) begin
              // Last byte: hold cnt at zero and capture the final flags.
              out_last_q  <= 1'b1;
              carry_out_q <= add_c8;
              ovf_q       <= ovf_d;
              state_q     <= DRAIN;
            end else begin
              cnt_q <= cnt_q - LEN_W'(1);
            end
          end else if (out_acc) begin
            out_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_acc) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign sum_byte  = sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mb_add_seq.sv
// Directed bench for mb_add_seq: byte streams with hand-computed results.
module tb_mb_add_seq;
  import mb_add_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [2:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum_byte;
  logic       out_last;
  logic       carry_out;
  logic       ovf;
  logic       busy;
  logic       done;
  state_e     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  mb_add_seq #(.LEN_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_byte    (a_byte),
    .b_byte    (b_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_byte  (sum_byte),
    .out_last  (out_last),
    .carry_out (carry_out),
    .ovf       (ovf),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one operation starting at the current (post-negedge) time. Output
  // backpressure is applied for stall_n cycles from stream cycle stall_at; a
  // stray start with altered sub/len is driven at stream cycle busy_start_at.
  task automatic run_op(input logic s, input logic [2:0] l,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input logic exp_c, input logic exp_v,
                        input int stall_at, input int stall_n, input int busy_start_at);
    int n;
    int sent;
    int cyc;
    bit fin;
    bit prev_stall;
    logic [7:0] prev_sum;
    logic [7:0] e;
    n = int'(l) + 1;
    sent = 0;
    cyc = 0;
    fin = 0;
    prev_stall = 0;
    prev_sum = 8'h00;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(exp_res[8*i +: 8]);
    start = 1'b1;
    sub = s;
    len = l;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", busy, 1);
    while (!fin && cyc < 64) begin
      in_valid = (sent < n);
      a_byte = (sent < 8) ? a[8*sent +: 8] : 8'h00;
      b_byte = (sent < 8) ? b[8*sent +: 8] : 8'h00;
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_n);
      start = (cyc == busy_start_at);
      sub = (cyc == busy_start_at) ? ~s : s;
      len = (cyc == busy_start_at) ? ~l : l;
      #1;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        if (prev_stall) check("stall_sum_hold", sum_byte, prev_sum);
        prev_stall = 1;
        prev_sum = sum_byte;
      end else begin
        prev_stall = 0;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sum_byte", sum_byte, e);
          check("out_last", out_last, (exp_q.size() == 0));
          if (exp_q.size() == 0) begin
            check("carry_out", carry_out, exp_c);
            check("ovf", ovf, exp_v);
            fin = 1;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (!fin) check("timeout", 0, 1);
    #1;
    check("done_pulse", done, 1);
    check("idle_after_op", dbg_state, IDLE);
    check("busy_after_op", busy, 0);
    check("out_valid_after_op", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    len = 3'd0;
    in_valid = 1'b0;
    a_byte = 8'h00;
    b_byte = 8'h00;
    out_ready = 1'b1;
    #1;
    // Reset values before any clock edge
    check("rst_state", dbg_state, IDLE);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // in_valid while idle does nothing
    in_valid = 1'b1;
    a_byte = 8'h55;
    b_byte = 8'h66;
    repeat (3) @(negedge clk);
    #1;
    check("idle_in_valid_out_valid", out_valid, 0);
    check("idle_in_valid_busy", busy, 0);
    in_valid = 1'b0;

    // 1-byte add FF+01
    run_op(1'b0, 3'd0, 64'hFF, 64'h01, 64'h00, 1'b1, 1'b0, 99, 0, 99);
    // 4-byte add, issued on the done cycle
    run_op(1'b0, 3'd3, 64'h00FFFFFF, 64'h1, 64'h01000000, 1'b0, 1'b0, 99, 0, 99);
    // 2-byte subtracts
    run_op(1'b1, 3'd1, 64'h0000, 64'h0001, 64'hFFFF, 1'b0, 1'b0, 99, 0, 99);
    run_op(1'b1, 3'd1, 64'h8000, 64'h0001, 64'h7FFF, 1'b1, 1'b1, 99, 0, 99);
    // Same 4-byte add with a 3-cycle output stall
    run_op(1'b0, 3'd3, 64'h00FFFFFF, 64'h1, 64'h01000000, 1'b0, 1'b0, 2, 3, 99);

    // Reset mid-RUN after 2 of 4 bytes
    @(negedge clk);
    start = 1'b1;
    sub = 1'b0;
    len = 3'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a_byte = 8'h11;
    b_byte = 8'h22;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_sum", sum_byte, 0);
    check("mid_rst_carry_ovf", {carry_out, ovf}, 0);
    check("mid_rst_busy_done", {busy, done, in_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_op(1'b0, 3'd0, 64'h7F, 64'h01, 64'h80, 1'b0, 1'b1, 99, 0, 99);

    // Max length with a stray start while busy
    run_op(1'b0, 3'd7, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
           64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0, 99, 0, 3);

    @(negedge clk);
    #1;
    check("final_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
